// File: rtl/counter_prog_if.sv
// ---------------------------------------------------------------------------
// counter_prog_if
// Bundles the control inputs and status outputs of the programmable counter.
//
// Parameters:
//   WIDTH       counter / limit / load value width
//   PRESCALE_W  prescaler divisor width
//
// Signals:
//   en, clr, load   count enable, synchronous clear, parallel load / start
//   load_val        value taken on load
//   dir             1 = count up, 0 = count down
//   mode            00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   limit           terminal value for up counting
//   presc_div       prescale divisor minus 1
//   count, tc       counter value, registered terminal-count pulse
//   busy, ovf       FSM in RUN, sticky overflow
//
// Modports:
//   master  drives the controls and observes the status (controller side)
//   slave   the counter itself
// ---------------------------------------------------------------------------
interface counter_prog_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  en;
    logic                  clr;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  dir;
    logic [1:0]            mode;
    logic [WIDTH-1:0]      limit;
    logic [PRESCALE_W-1:0] presc_div;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  busy;
    logic                  ovf;

    modport master (
        output en, clr, load, load_val, dir, mode, limit, presc_div,
        input  count, tc, busy, ovf
    );

    modport slave (
        input  en, clr, load, load_val, dir, mode, limit, presc_div,
        output count, tc, busy, ovf
    );
endinterface

// File: rtl/counter_prog.sv
// ---------------------------------------------------------------------------
// counter_prog
// Programmable up/down counter with runtime limit, parallel load, synchronous
// clear and wrap / saturate / one-shot modes. Produces a registered
// terminal-count pulse (tc) and a sticky overflow flag (ovf).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    counter_prog_if.slave (controls in, count/tc/busy/ovf out)
//
// Optional feature:
//   COUNTER_PRESCALE_EN  when defined, a PRESCALE_W-bit prescaler gates the
//                        count step to once every presc_div+1 enabled cycles.
//                        When undefined, every enabled cycle is a step and
//                        presc_div is ignored.
// ---------------------------------------------------------------------------
module counter_prog #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    counter_prog_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             tc_q, tc_d;
    logic             tick;
    logic             step;

`ifdef COUNTER_PRESCALE_EN
    localparam logic [PRESCALE_W-1:0] PONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] presc_q, presc_d;

    // The prescaler fires when it reaches the divisor; >= keeps it from
    // running the full range if presc_div is lowered below the current value.
    assign tick = (presc_q >= bus.presc_div);

    // Prescaler advances only while enabled, and restarts on clear, load
    // or after each tick.
    always_comb begin
        presc_d = presc_q;
        if (bus.clr || bus.load) begin
            presc_d = '0;
        end else if (bus.en) begin
            presc_d = tick ? '0 : presc_q + PONE;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic unused_presc;

    assign tick         = 1'b1;
    assign unused_presc = ^bus.presc_div;
`endif

    assign step = bus.en && tick;

    // State register: FSM state, count, sticky overflow and the tc pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            tc_q    <= tc_d;
        end
    end

    // Next-state logic. Clear beats load beats step; a discarded step never
    // produces tc. Mode, direction and limit are read fresh on every step.
    always_comb begin
        logic             is_sat;
        logic             is_one;
        logic             at_term;
        logic             step_term;
        logic [WIDTH-1:0] step_val;
        logic [WIDTH-1:0] wrap_val;

        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        tc_d    = 1'b0;

        is_sat    = (bus.mode == 2'b01);
        is_one    = (bus.mode == 2'b10);
        at_term   = bus.dir ? (count_q >= bus.limit) : (count_q == '0);
        step_val  = bus.dir ? (count_q + ONE) : (count_q - ONE);
        step_term = bus.dir ? (step_val >= bus.limit) : (step_val == '0);
        wrap_val  = bus.dir ? '0 : bus.limit;

        if (bus.clr) begin
            state_d = IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            state_d = RUN;
            count_d = bus.load_val;
            ovf_d   = 1'b0;
        end else if (step) begin
            case (state_q)
                HOLD: begin
                    ovf_d = 1'b1;
                end
                default: begin
                    // One-shot runs only start from load, so IDLE ignores steps.
                    if (!(state_q == IDLE && is_one)) begin
                        if (!is_sat && !is_one) begin
                            state_d = RUN;
                            if (at_term) begin
                                count_d = wrap_val;
                                tc_d    = 1'b1;
                                ovf_d   = 1'b1;
                            end else begin
                                count_d = step_val;
                            end
                        end else if (at_term) begin
                            state_d = HOLD;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = step_val;
                            tc_d    = step_term;
                            state_d = step_term ? HOLD : RUN;
                        end
                    end
                end
            endcase
        end
    end

    // Output logic: everything comes straight from registers.
    always_comb begin
        bus.count = count_q;
        bus.tc    = tc_q;
        bus.ovf   = ovf_q;
        bus.busy  = (state_q == RUN);
    end

endmodule

// File: doc/counter_prog.md
# counter_prog

Programmable up/down counter: the next generation of the team's basic terminal-count counter. Adds runtime limit, direction, parallel load, synchronous clear, and wrap/saturate/one-shot modes, plus a registered terminal-count pulse and a sticky overflow flag. It is used as the general timer/event-count primitive in control paths, with an optional compile-time enable prescaler.

## Interface
- WIDTH, 8, counter and limit width (>=2)
- PRESCALE_W, 4, prescaler divisor width (used only with the prescaler compiled in)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  count enable
- clr  in  1  synchronous clear
- load  in  1  synchronous parallel load / one-shot start
- load_val  in  WIDTH  load value
- dir  in  1  1 = up, 0 = down
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- limit  in  WIDTH  runtime terminal value for up counting
- presc_div  in  PRESCALE_W  prescale divisor minus 1
- count  out  WIDTH  counter value
- tc  out  1  registered terminal-count pulse
- busy  out  1  FSM in RUN
- ovf  out  1  sticky overflow

## Operation
- step = en && tick; tick = 1 unless the prescaler is compiled in.
- Priority each cycle: clr > load > step.
- clr: count=0, ovf=0, prescaler=0, FSM->IDLE.
- load: count=load_val, ovf=0, prescaler=0, FSM->RUN (any mode).
- Terminal condition: up: count >= limit; down: count == 0. Using >= makes an out-of-range load terminate on its next up step.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: in wrap or saturate mode, a step advances count and moves to RUN. In one-shot mode, steps are ignored.
  - RUN: advances count as described under Wrap, Saturate and One-shot below.
  - HOLD: count frozen. Exit only via load (->RUN) or clr (->IDLE).
- Wrap: a step at terminal sets count to 0 (up) or limit (down), and sets tc and ovf. Otherwise count ±1. FSM stays in RUN.
- Saturate: a step from non-terminal moves count ±1. If the new value is terminal, tc=1 and FSM->HOLD. A step requested in HOLD sets ovf.
- One-shot: same as saturate, but IDLE ignores steps. A run starts only on load.
- If count is already terminal when a step occurs in saturate or one-shot RUN, count is held, FSM->HOLD, and tc=1.
- mode, dir and limit are sampled on every step. Changes take effect at the next step with no restart.
- busy = (state == RUN).

## Timing
- Reset values: count=0, tc=0, busy=0, ovf=0, FSM=IDLE, prescaler=0.
- count, ovf and busy update on the clock edge at which step, load or clr is sampled.
- tc is a single-cycle pulse, high in the cycle after the terminal step.
- tc never asserts on load or clr, even if load_val is terminal.
- A step coincident with load or clr is discarded; no tc results.
- Reset asserted mid-count returns all outputs to reset values immediately (asynchronously).
- en low freezes count and the prescaler. No outputs change except that tc drops.

## Configuration
- COUNTER_PRESCALE_EN defined:
  - A PRESCALE_W-bit prescaler counts while en=1.
  - tick pulses once every presc_div+1 enabled cycles, and the prescaler then restarts from 0.
  - presc_div=0 means tick every enabled cycle.
- COUNTER_PRESCALE_EN undefined: tick=1 constant, presc_div is ignored, and no prescaler flops are present.

## Test plan
- Wrap, WIDTH=8, limit=5, dir=1, en held: count goes 0,1,2,3,4,5,0. tc is high for one cycle after the 5->0 step. ovf=1.
- Down wrap, limit=3, load_val=1: count goes 1,0,3. tc fires after the 0->3 step.
- Saturate, limit=4, up: count stops at 4 with tc pulsed once. busy=0. Further en sets ovf=1 while count stays 4. A subsequent load clears ovf.
- One-shot: en alone keeps count at 0. Load 2, up, limit=6: busy is high for 4 steps, count ends at 6, tc pulses, then HOLD.
- Priority: clr, load and en all high at count=3 gives count=0, ovf=0, no tc. Load+en with load_val=7 gives count=7, no increment.
- COUNTER_PRESCALE_EN, presc_div=2: count increments once per 3 enabled cycles. Dropping en for 2 cycles delays the next increment by exactly 2 cycles. Async rst_n asserted mid-run zeroes all outputs.
